// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit-PC / 16-bit-instruction core:
// field widths, opcodes, decode FSM states and the ID/EX register layout.
package core_pkg;

    localparam int DW = 8;
    localparam int IW = 16;
    localparam int RW = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPLAY = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [3:0]    opcode;
        logic [RW-1:0] rd;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
    } idex_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Signal bundle between decode and its neighbours (fetch, EX/MEM hazard
// taps, writeback port, ID/EX register). Names match the legacy port list.
interface decode_stage_if;
    import core_pkg::*;

    logic [IW-1:0] if_instruction;
    logic [DW-1:0] if_pc;
    logic          if_valid;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic [RW-1:0] ex_rd;
    logic          mem_reg_write;
    logic [RW-1:0] mem_rd;
    logic          wb_we;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    logic          stall;
    logic          flush;
    logic          PC_sel;
    logic          Jump;
    logic [DW-1:0] branch_target;
    logic          id_valid;
    logic [3:0]    id_opcode;
    logic [RW-1:0] id_rd;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic [DW-1:0] id_a;
    logic [DW-1:0] id_b;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] id_pc;
    logic          halted;

    modport master (
        output if_instruction, if_pc, if_valid, ex_reg_write, ex_mem_read, ex_rd,
               mem_reg_write, mem_rd, wb_we, wb_rd, wb_data,
        input  stall, flush, PC_sel, Jump, branch_target, id_valid, id_opcode,
               id_rd, id_rs1, id_rs2, id_a, id_b, id_imm, id_pc, halted
    );

    modport slave (
        input  if_instruction, if_pc, if_valid, ex_reg_write, ex_mem_read, ex_rd,
               mem_reg_write, mem_rd, wb_we, wb_rd, wb_data,
        output stall, flush, PC_sel, Jump, branch_target, id_valid, id_opcode,
               id_rd, id_rs1, id_rs2, id_a, id_b, id_imm, id_pc, halted
    );

endinterface

// File: rtl/regfile16x8.sv
// Register file: one write port, two combinational read ports that see a
// same-cycle write (write-through bypass). R0 is an ordinary register.
module regfile16x8 #(
    parameter int NREGS = 16,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(NREGS)-1:0] raddr1_i,
    output logic [DW-1:0]            rdata1_o,
    input  logic [$clog2(NREGS)-1:0] raddr2_i,
    output logic [DW-1:0]            rdata2_o
);

    logic [DW-1:0] mem_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
    assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, register read, load-use / branch-operand
// hazards, BEQ/JMP resolution, RUN/REPLAY/HALTED control and the ID/EX register.
module decode_stage #(
    parameter int NREGS = 16,
    parameter int DW    = 8
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave dif
);
    import core_pkg::*;

    state_t        state_q, state_d;
    idex_t         id_q, id_d;
    logic [3:0]    op;
    logic [RW-1:0] rd, rs1, rs2;
    logic [RW-1:0] raddr1, raddr2;
    logic [DW-1:0] rdata1, rdata2;
    logic          cur_valid, active, go, issue;
    logic          is_beq, is_jmp, is_st;
    logic          load_use, br_haz, stall, pc_sel, jump;

    assign op  = dif.if_instruction[15:12];
    assign rd  = dif.if_instruction[11:8];
    assign rs1 = dif.if_instruction[7:4];
    assign rs2 = dif.if_instruction[3:0];

    assign is_beq = (op == OP_BEQ);
    assign is_jmp = (op == OP_JMP);
    assign is_st  = (op == OP_ST);

    // Port 1 reads rs1 (BEQ: rd); port 2 reads rs2 (ST data: rd, BEQ: rs1),
    // so the BEQ compare and both ST operands come straight off the ports.
    assign raddr1 = is_beq ? rd : rs1;
    assign raddr2 = is_st ? rd : (is_beq ? rs1 : rs2);

    regfile16x8 #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk      (clk),
        .rst      (reset),
        .we_i     (dif.wb_we),
        .waddr_i  (dif.wb_rd),
        .wdata_i  (dif.wb_data),
        .raddr1_i (raddr1),
        .rdata1_o (rdata1),
        .raddr2_i (raddr2),
        .rdata2_o (rdata2)
    );

    assign cur_valid = dif.if_valid || (state_q == REPLAY);
    assign active    = cur_valid && (state_q != HALTED);

    always_comb begin
        load_use = 1'b0;
        if (is_alu(op))                         load_use = (dif.ex_rd == rs1) || (dif.ex_rd == rs2);
        else if (op == OP_ADDI || op == OP_LD)  load_use = (dif.ex_rd == rs1);
        else if (is_st)                         load_use = (dif.ex_rd == rs1) || (dif.ex_rd == rd);
        load_use = load_use && dif.ex_mem_read;
    end

    assign br_haz = is_beq &&
        ((dif.ex_reg_write  && ((dif.ex_rd  == rd) || (dif.ex_rd  == rs1))) ||
         (dif.mem_reg_write && ((dif.mem_rd == rd) || (dif.mem_rd == rs1))));

    assign stall  = active && (load_use || br_haz);
    assign go     = active && !stall;
    assign pc_sel = go && is_beq && (rdata1 == rdata2);
    assign jump   = go && is_jmp;
    assign issue  = go && !is_beq && !is_jmp;

    assign dif.stall         = stall;
    assign dif.PC_sel        = pc_sel;
    assign dif.Jump          = jump;
    assign dif.flush         = pc_sel || jump;
    assign dif.branch_target = (active && is_beq) ? dif.if_pc + {{(DW-RW){rs2[RW-1]}}, rs2} : '0;

    always_comb begin
        id_d = '0;
        if (issue) begin
            id_d.valid  = 1'b1;
            id_d.opcode = (op >= 4'hB && op <= 4'hE) ? OP_NOP : op;
            id_d.rd     = rd;
            id_d.rs1    = rs1;
            id_d.rs2    = rs2;
            id_d.a      = rdata1;
            id_d.b      = rdata2;
            id_d.imm    = dif.if_instruction[7:0];
            id_d.pc     = dif.if_pc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED:  state_d = HALTED;
            default: begin
                if (stall)                       state_d = REPLAY;
                else if (issue && op == OP_HLT)  state_d = HALTED;
                else                             state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign dif.id_valid  = id_q.valid;
    assign dif.id_opcode = id_q.opcode;
    assign dif.id_rd     = id_q.rd;
    assign dif.id_rs1    = id_q.rs1;
    assign dif.id_rs2    = id_q.rs2;
    assign dif.id_a      = id_q.a;
    assign dif.id_b      = id_q.b;
    assign dif.id_imm    = id_q.imm;
    assign dif.id_pc     = id_q.pc;
    assign dif.halted    = (state_q == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts fetch controls
// each cycle and every issued ID/EX word; a monitor checks what the DUT presents.
module tb_decode_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if dif();

    decode_stage #(.NREGS(16), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    typedef struct packed {
        logic       stall, flush, pcsel, jump;
        logic [7:0] tgt;
        logic       halted;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] op, rd, rs1, rs2;
        logic [7:0] a, b, imm, pc;
    } idx_t;

    ctrl_t ctrl_q[$];
    idx_t  id_q[$];
    int    tests = 0;
    int    fails = 0;

    logic [7:0]  m_regs [16];
    bit          m_replay, m_halted;
    bit          last_stall, last_flush;
    logic [15:0] prev_ins;
    logic [7:0]  prev_pc;

    task automatic step(input logic rst, input logic [15:0] ins, input logic [7:0] pc, input logic v,
                        input logic exw, input logic exm, input logic [3:0] exrd,
                        input logic mw, input logic [3:0] mrd,
                        input logic we, input logic [3:0] wrd, input logic [7:0] wd);
        logic [3:0] op, rd, r1, r2;
        logic [3:0] srcs[$];
        logic [7:0] va, vb, vrd, vr1, vr2;
        bit act, lu, bh, st, ps, jp, iss;
        int off;
        ctrl_t c;
        idx_t  e;
        @(negedge clk);
        reset = rst;
        dif.if_instruction = ins; dif.if_pc = pc; dif.if_valid = v;
        dif.ex_reg_write = exw; dif.ex_mem_read = exm; dif.ex_rd = exrd;
        dif.mem_reg_write = mw; dif.mem_rd = mrd;
        dif.wb_we = we; dif.wb_rd = wrd; dif.wb_data = wd;
        prev_ins = ins; prev_pc = pc;
        if (rst) begin
            id_q.delete();
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_replay = 0; m_halted = 0;
            ctrl_q.push_back('0);
            last_stall = 0; last_flush = 0;
            return;
        end
        op = ins[15:12]; rd = ins[11:8]; r1 = ins[7:4]; r2 = ins[3:0];
        vrd = (we && wrd == rd) ? wd : m_regs[rd];
        vr1 = (we && wrd == r1) ? wd : m_regs[r1];
        vr2 = (we && wrd == r2) ? wd : m_regs[r2];
        act = (v || m_replay) && !m_halted;
        if (op >= 1 && op <= 5) begin srcs.push_back(r1); srcs.push_back(r2); end
        else if (op == 6 || op == 7) srcs.push_back(r1);
        else if (op == 8) begin srcs.push_back(r1); srcs.push_back(rd); end
        lu = 0;
        foreach (srcs[i]) if (exm && exrd == srcs[i]) lu = 1;
        bh = (op == 9) && ((exw && (exrd == rd || exrd == r1)) || (mw && (mrd == rd || mrd == r1)));
        st = act && (lu || bh);
        ps = act && !st && op == 9 && vrd == vr1;
        jp = act && !st && op == 10;
        iss = act && !st && op != 9 && op != 10;
        off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
        c.stall = st; c.flush = ps || jp; c.pcsel = ps; c.jump = jp;
        c.tgt = (act && op == 9) ? 8'((int'(pc) + off + 256) % 256) : 8'h00;
        c.halted = m_halted;
        ctrl_q.push_back(c);
        if (iss) begin
            va = vr1;
            vb = (op == 8) ? vrd : vr2;
            e.op = (op >= 11 && op <= 14) ? 4'h0 : op;
            e.rd = rd; e.rs1 = r1; e.rs2 = r2;
            e.a = va; e.b = vb; e.imm = ins[7:0]; e.pc = pc;
            id_q.push_back(e);
            if (op == 15) m_halted = 1;
        end
        if (we) m_regs[wrd] = wd;
        m_replay = st;
        last_stall = st; last_flush = ps || jp;
    endtask

    task automatic idle();
        step(0, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);
    endtask

    task automatic rand_step();
        logic [15:0] ins;
        logic [7:0]  pc;
        logic        v;
        logic [3:0]  op;
        if ($urandom_range(0, 49) == 0) begin
            step(1, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);
            return;
        end
        if (last_stall) begin
            ins = prev_ins; pc = prev_pc; v = 0;
        end else begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h1;
            ins = {op, 12'($urandom)};
            pc  = 8'($urandom);
            v   = last_flush ? 1'b0 : ($urandom_range(0, 9) != 0);
        end
        step(0, ins, pc, v,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 4'($urandom),
             $urandom_range(0, 3) == 0, 4'($urandom),
             $urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom_range(0, 3)));
    endtask

    initial begin : monitor
        ctrl_t c, a;
        idx_t  e, g;
        forever begin
            @(negedge clk);
            #2;
            if (ctrl_q.size() > 0) begin
                c = ctrl_q.pop_front();
                a = {dif.stall, dif.flush, dif.PC_sel, dif.Jump, dif.branch_target, dif.halted};
                tests++;
                if (a !== c) begin
                    fails++;
                    $display("FAIL ctrl @%0t: got stall/flush/pcsel/jump/tgt/halted=%h required %h", $time, a, c);
                end
            end
            if (dif.id_valid === 1'b1) begin
                tests++;
                g = {dif.id_opcode, dif.id_rd, dif.id_rs1, dif.id_rs2, dif.id_a, dif.id_b, dif.id_imm, dif.id_pc};
                if (id_q.size() == 0) begin
                    fails++;
                    $display("FAIL idex_spurious @%0t: got %h, none required", $time, g);
                end else begin
                    e = id_q.pop_front();
                    if (g !== e) begin
                        fails++;
                        $display("FAIL idex @%0t: got %h required %h", $time, g, e);
                    end
                end
            end else if (dif.id_valid !== 1'b0) begin
                tests++; fails++;
                $display("FAIL id_valid @%0t: got %b required 0/1", $time, dif.id_valid);
            end
        end
    end

    initial begin : stimulus
        dif.if_instruction = '0; dif.if_pc = '0; dif.if_valid = 0;
        dif.ex_reg_write = 0; dif.ex_mem_read = 0; dif.ex_rd = '0;
        dif.mem_reg_write = 0; dif.mem_rd = '0;
        dif.wb_we = 0; dif.wb_rd = '0; dif.wb_data = '0;
        step(1, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);
        step(0, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1, 4'h1, 8'h05);
        step(0, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1, 4'h2, 8'h07);
        step(0, 16'h1312, 8'h10, 1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // ADD R3,R1,R2
        step(0, 16'h1421, 8'h11, 1, 1, 1, 4'h2, 0, 4'h0, 0, 4'h0, 8'h00);  // load-use stall
        step(0, 16'h1421, 8'h11, 0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // replay issues
        step(0, 16'h911C, 8'h01, 1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // BEQ taken -> 0xFD
        idle();
        step(0, 16'hA400, 8'h02, 1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // JMP 0x40
        idle();
        step(0, 16'h912C, 8'h03, 1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // BEQ not taken
        step(0, 16'h911C, 8'h04, 1, 0, 0, 4'h0, 1, 4'h1, 0, 4'h0, 8'h00);  // branch-operand stall (MEM)
        step(0, 16'h911C, 8'h04, 0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);
        idle();
        step(0, 16'h1011, 8'h05, 1, 0, 0, 4'h0, 0, 4'h0, 1, 4'h1, 8'h9A);  // write bypass
        step(0, 16'h8312, 8'h06, 1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // ST operands
        step(0, 16'h1421, 8'h07, 1, 1, 1, 4'h1, 0, 4'h0, 0, 4'h0, 8'h00);  // stall...
        step(1, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // ...reset mid-REPLAY
        idle();
        step(0, 16'hF000, 8'h08, 1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // HLT
        for (int i = 0; i < 3; i++)
            step(0, 16'h1312, 8'h09, 1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);
        step(1, 16'h0000, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00);  // reset mid-HALTED
        idle();
        for (int i = 0; i < 1500; i++) rand_step();
        idle();
        idle();
        @(negedge clk);
        #3;
        tests++;
        if (id_q.size() != 0 || ctrl_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d idex / %0d ctrl pending, required 0/0", id_q.size(), ctrl_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
